uart_tx_stream: RTL and testbench

Parametrised UART transmitter for the top-level serial link. It replaces the fixed-payload, fixed-timing TX pattern with a real byte stream: it accepts words over a valid/ready handshake and serialises them with configurable baud, data width, parity and stop bits. It honours the host's CTS flow control. It sits between on-chip data producers and the board pin uart_tx, and runs in the 30 MHz clk domain.

---
 rtl/uart_tx_stream.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_stream.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_stream.sv
// UART transmitter: valid/ready word stream in, framed serial line out.
// Configurable baud, data width, parity and stop bits, with optional CTS gating.
module uart_tx_stream #(
    parameter int unsigned CLK_HZ    = 30000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned USE_CTS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 uart_cts,
    output logic                 uart_tx,
    output logic                 busy
);

    localparam int unsigned DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned DIV_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int unsigned BIT_W = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_stream: DIV must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("uart_tx_stream: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_stream: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_stream: STOP_BITS must be 1 or 2");
    end

    logic [2:0]           state, state_d;
    logic [DIV_W-1:0]     div_cnt, div_d;
    logic [BIT_W-1:0]     bit_cnt, bit_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic                 par_bit, par_d;
    logic                 line_d;
    logic                 cts_meta, cts_sync;
    logic                 cts_ok;
    logic                 accept;
    logic                 term;

    // Two-flop synchroniser; resets to "not clear" so nothing starts before CTS is seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cts_meta <= 1'b1;
            cts_sync <= 1'b1;
        end else begin
            cts_meta <= uart_cts;
            cts_sync <= cts_meta;
        end
    end

    assign cts_ok   = (cts_sync == 1'b0) || (USE_CTS == 0);
    assign tx_ready = (state == ST_IDLE) && cts_ok;
    assign busy     = (state != ST_IDLE);
    assign accept   = tx_valid && tx_ready;
    assign term     = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_d;
            div_cnt <= div_d;
            bit_cnt <= bit_d;
            shreg   <= shreg_d;
            par_bit <= par_d;
            uart_tx <= line_d;
        end
    end

    // Frame sequencing; the line level is derived from the next state so it registers with it.
    always_comb begin
        state_d = state;
        div_d   = div_cnt;
        bit_d   = bit_cnt;
        shreg_d = shreg;
        par_d   = par_bit;
        line_d  = 1'b1;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    shreg_d = tx_data;
                    par_d   = (PARITY == 1) ? ~(^tx_data) : (^tx_data);
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (term) begin
                    div_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    div_d = div_cnt + DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (term) begin
                    div_d   = '0;
                    shreg_d = shreg >> 1;
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    div_d = div_cnt + DIV_W'(1);
                end
            end
            ST_PARITY: begin
                if (term) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    div_d = div_cnt + DIV_W'(1);
                end
            end
            ST_STOP: begin
                if (term) begin
                    div_d = '0;
                    if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        bit_d = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    div_d = div_cnt + DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
                bit_d   = '0;
            end
        endcase

        case (state_d)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shreg_d[0];
            ST_PARITY: line_d = par_d;
            default:   line_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: five configurations checked against a bit-list frame model.
module tb_uart_tx_stream;

    logic       clk;
    logic       rst;
    logic [8:0] data_a  [5];
    logic       valid_a [5];
    logic       cts_a   [5];
    wire        line_a  [5];
    wire        ready_a [5];
    wire        busy_a  [5];

    int errors;
    int checks;
    int cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_stream #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(rst), .tx_data(data_a[0][7:0]), .tx_valid(valid_a[0]), .tx_ready(ready_a[0]),
        .uart_cts(cts_a[0]), .uart_tx(line_a[0]), .busy(busy_a[0]));
    uart_tx_stream #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(rst), .tx_data(data_a[1][7:0]), .tx_valid(valid_a[1]), .tx_ready(ready_a[1]),
        .uart_cts(cts_a[1]), .uart_tx(line_a[1]), .busy(busy_a[1]));
    uart_tx_stream #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset(rst), .tx_data(data_a[2][7:0]), .tx_valid(valid_a[2]), .tx_ready(ready_a[2]),
        .uart_cts(cts_a[2]), .uart_tx(line_a[2]), .busy(busy_a[2]));
    uart_tx_stream #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
        .clk(clk), .reset(rst), .tx_data(data_a[3][6:0]), .tx_valid(valid_a[3]), .tx_ready(ready_a[3]),
        .uart_cts(cts_a[3]), .uart_tx(line_a[3]), .busy(busy_a[3]));
    uart_tx_stream u_def (
        .clk(clk), .reset(rst), .tx_data(data_a[4][7:0]), .tx_valid(valid_a[4]), .tx_ready(ready_a[4]),
        .uart_cts(cts_a[4]), .uart_tx(line_a[4]), .busy(busy_a[4]));

    // Accept one word on instance idx and check every line level of its frame against the model.
    task automatic run_frame(input int idx, input int dbits, input int par, input int stops,
                             input int div, input logic [8:0] d, input logic [8:0] nxt_d,
                             input logic nxt_v, input int cts_drop, input logic exp_ready,
                             output int acc_cyc);
        logic exp_bits [16];
        int   n, w, ones;
        logic bad, bad_busy;
        n = 0;
        exp_bits[n++] = 1'b0;
        ones = 0;
        for (int i = 0; i < dbits; i++) begin
            exp_bits[n++] = d[i];
            ones += int'(d[i]);
        end
        if (par == 1) exp_bits[n++] = (ones % 2 == 0);
        if (par == 2) exp_bits[n++] = (ones % 2 == 1);
        for (int i = 0; i < stops; i++) exp_bits[n++] = 1'b1;

        data_a[idx]  = d;
        valid_a[idx] = 1'b1;
        w = 0;
        while (!(valid_a[idx] && ready_a[idx]) && w < 400) begin
            @(negedge clk);
            w++;
        end
        acc_cyc = cyc;
        checks++;
        if (!(valid_a[idx] && ready_a[idx])) begin
            errors++;
            $display("FAIL accept_timeout inst=%0d: ready=%b after %0d cycles, required 1", idx, ready_a[idx], w);
            valid_a[idx] = 1'b0;
            return;
        end
        bad_busy = 1'b0;
        for (int b = 0; b < n; b++) begin
            bad = 1'b0;
            for (int k = 0; k < div; k++) begin
                @(negedge clk);
                if (b * div + k == 0) begin
                    valid_a[idx] = nxt_v;
                    data_a[idx]  = nxt_d;
                end
                if (b * div + k == cts_drop) cts_a[idx] = 1'b1;
                if (line_a[idx] !== exp_bits[b]) bad = 1'b1;
                if (busy_a[idx] !== 1'b1) bad_busy = 1'b1;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL frame_bit inst=%0d word=%h bit=%0d: line=%b, required %b for %0d cycles",
                         idx, d, b, line_a[idx], exp_bits[b], div);
            end
        end
        checks++;
        if (bad_busy) begin
            errors++;
            $display("FAIL busy_frame inst=%0d: busy dropped during frame, required 1", idx);
        end
        @(negedge clk);
        checks++;
        if (line_a[idx] !== 1'b1 || busy_a[idx] !== 1'b0 || ready_a[idx] !== exp_ready) begin
            errors++;
            $display("FAIL frame_end inst=%0d: line=%b busy=%b ready=%b, required 1 0 %b",
                     idx, line_a[idx], busy_a[idx], ready_a[idx], exp_ready);
        end
    endtask

    task automatic test_reset();
        int w;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (line_a[i] !== 1'b1 || ready_a[i] !== 1'b0 || busy_a[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state inst=%0d: line=%b ready=%b busy=%b, required 1 0 0",
                         i, line_a[i], ready_a[i], busy_a[i]);
            end
        end
        rst = 1'b0;
        w = 0;
        while (ready_a[0] !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w > 3) begin
            errors++;
            $display("FAIL reset_ready: ready after %0d cycles, required <= 3", w);
        end
    endtask

    task automatic test_8n1();
        int a;
        run_frame(0, 8, 0, 1, 16, 9'h043, 9'($urandom), 1'b0, -1, 1'b1, a);
        repeat (3) run_frame(0, 8, 0, 1, 16, 9'($urandom) & 9'h0FF, 9'($urandom), 1'b0, -1, 1'b1, a);
    endtask

    task automatic test_parity();
        int a;
        run_frame(1, 8, 2, 1, 16, 9'h043, 9'($urandom), 1'b0, -1, 1'b1, a);
        run_frame(2, 8, 1, 1, 16, 9'h043, 9'($urandom), 1'b0, -1, 1'b1, a);
        repeat (2) begin
            run_frame(1, 8, 2, 1, 16, 9'($urandom) & 9'h0FF, 9'($urandom), 1'b0, -1, 1'b1, a);
            run_frame(2, 8, 1, 1, 16, 9'($urandom) & 9'h0FF, 9'($urandom), 1'b0, -1, 1'b1, a);
        end
    endtask

    task automatic test_7o2();
        int a;
        run_frame(3, 7, 1, 2, 16, 9'h055, 9'($urandom), 1'b0, -1, 1'b1, a);
        repeat (2) run_frame(3, 7, 1, 2, 16, 9'($urandom) & 9'h07F, 9'($urandom), 1'b0, -1, 1'b1, a);
    endtask

    task automatic test_back_to_back();
        int a1, a2;
        run_frame(0, 8, 0, 1, 16, 9'h0A5, 9'h03C, 1'b1, -1, 1'b1, a1);
        run_frame(0, 8, 0, 1, 16, 9'h03C, 9'($urandom), 1'b0, -1, 1'b1, a2);
        checks++;
        if (a2 - a1 != 161) begin
            errors++;
            $display("FAIL b2b_spacing: accepts %0d cycles apart, required 161", a2 - a1);
        end
    endtask

    task automatic test_cts();
        int   w, a;
        logic bad;
        cts_a[0] = 1'b1;
        repeat (4) @(negedge clk);
        data_a[0]  = 9'($urandom) & 9'h0FF;
        valid_a[0] = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ready_a[0] !== 1'b0 || line_a[0] !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL cts_block: ready=%b line=%b while CTS high, required 0 1", ready_a[0], line_a[0]);
        end
        cts_a[0] = 1'b0;
        w = 0;
        while (ready_a[0] !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w > 3) begin
            errors++;
            $display("FAIL cts_release: ready after %0d cycles, required <= 3", w);
        end
        run_frame(0, 8, 0, 1, 16, 9'($urandom) & 9'h0FF, 9'($urandom), 1'b1, 80, 1'b0, a);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ready_a[0] !== 1'b0 || line_a[0] !== 1'b1 || busy_a[0] !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL cts_hold: ready=%b line=%b busy=%b after frame with CTS high, required 0 1 0",
                     ready_a[0], line_a[0], busy_a[0]);
        end
        valid_a[0] = 1'b0;
        cts_a[0]   = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int w, a;
        data_a[0]  = 9'h043;
        valid_a[0] = 1'b1;
        w = 0;
        while (ready_a[0] !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        repeat (72) begin
            @(negedge clk);
            valid_a[0] = 1'b0;
        end
        checks++;
        if (line_a[0] !== 1'b0 || busy_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_bit3: line=%b busy=%b, required 0 1", line_a[0], busy_a[0]);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (line_a[0] !== 1'b1 || busy_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: line=%b busy=%b, required 1 0", line_a[0], busy_a[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        w = 0;
        while (ready_a[0] !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w > 3) begin
            errors++;
            $display("FAIL reset_release_ready: ready after %0d cycles, required <= 3", w);
        end
        run_frame(0, 8, 0, 1, 16, 9'h043, 9'($urandom), 1'b0, -1, 1'b1, a);
    endtask

    task automatic test_defaults();
        int w, cnt, a;
        data_a[4]  = (9'($urandom) & 9'h0FF) | 9'h001;
        valid_a[4] = 1'b1;
        w = 0;
        while (ready_a[4] !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        valid_a[4] = 1'b0;
        cnt = 0;
        while (line_a[4] === 1'b0 && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 260) begin
            errors++;
            $display("FAIL default_bit_period: start bit %0d cycles, required 260", cnt);
        end
        w = 0;
        while (busy_a[4] !== 1'b0 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        run_frame(4, 8, 0, 1, 260, 9'($urandom) & 9'h0FF, 9'($urandom), 1'b0, -1, 1'b1, a);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        rst    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_a[i]  = '0;
            valid_a[i] = 1'b0;
            cts_a[i]   = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_8n1();
        test_parity();
        test_7o2();
        test_back_to_back();
        test_cts();
        test_reset_mid();
        test_defaults();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
